hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
//  Pipeline sequencer for the 5-stage RV32 core (F/D/E/M/W).
//  - Generates stall, flush and forwarding controls for the decode/execute/memory pipeline registers.
//  - Holds the entire pipeline while a variable-latency data-memory access completes, using a
//    dmem_req/dmem_ready handshake.
//  - Detects a memory-wait timeout and parks the core in a sticky error state.
// PARAMETERS
//  MEM_TIMEOUT  16  maximum consecutive wait cycles allowed in MEM_WAIT before entering ERROR (>=2)
//  PERF_W       32  width of the performance counters (used only with HAZARD_PERF_EN)
// PORTS
//  clk          in   1  core clock
//  reset_n      in   1  asynchronous reset, active low
//  Rs1D,Rs2D    in   5  source registers of the instruction in decode
//  Rs1E,Rs2E    in   5  source registers of the instruction in execute
//  RdE,RdM,RdW  in   5  destination registers in execute, memory and writeback
//  ResultSrcE0  in   1  instruction in execute is a load (ResultSrcE[0])
//  RegWriteM    in   1  instruction in memory writes the register file
//  RegWriteW    in   1  instruction in writeback writes the register file
//  PCSrcE       in   1  taken branch or jump resolved in execute
//  dmem_req     in   1  instruction in memory accesses data memory (load or store)
//  dmem_ready   in   1  data memory completes the access this cycle
//  StallF,StallD,StallE,StallM  out 1  hold the PC / D / E / M pipeline registers
//  FlushD,FlushE  out 1  clear the D / E pipeline registers to a bubble (synchronous, in that stage)
//  ForwardAE,ForwardBE  out 2  ALU operand select: 00 register file, 01 ResultW, 10 ALUResultM
//  mem_error    out  1  sticky memory-timeout flag
//  stall_cycles,flush_count  out PERF_W  performance counters (only with HAZARD_PERF_EN)
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, mem_error=0, counters=0.
//   - While reset_n is low, all Stall*/Flush* outputs are 0 and Forward* outputs are 00.
//  Forwarding (combinational, operand A shown; B is identical using Rs2E):
//   - 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
//   - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
//   - else 00.
//   - The memory-stage match wins over the writeback-stage match.
//  Hazard terms:
//   - lw_stall  = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) && !PCSrcE.
//   - mem_stall = dmem_req && !dmem_ready.
//  Priority, highest first:
//   1. state==ERROR: StallF/D/E/M=1, all flushes 0.
//   2. mem_stall: StallF/D/E/M=1, FlushD=FlushE=0. Nothing advances; PCSrcE and lw_stall are
//      held and re-evaluated when the pipeline moves.
//   3. PCSrcE: FlushD=1, FlushE=1, no stalls.
//   4. lw_stall: StallF=StallD=1, FlushE=1 (one-cycle bubble).
//   5. Otherwise all stall/flush outputs are 0.
//  FSM (state and wait_cnt registered; outputs combinational from state and inputs):
//   RUN:
//    - mem_stall -> MEM_WAIT, wait_cnt<=1.
//    - otherwise stay in RUN.
//   MEM_WAIT:
//    - dmem_ready -> RUN, wait_cnt<=0. The pipeline advances in that same cycle.
//    - else if wait_cnt==MEM_TIMEOUT-1 -> ERROR.
//    - else wait_cnt<=wait_cnt+1.
//    - If dmem_req drops without dmem_ready: -> RUN, wait_cnt<=0 (request withdrawn).
//   ERROR:
//    - Terminal; mem_error=1; only reset_n exits.
//  Latency:
//   - dmem_ready returned in the same cycle as dmem_req costs 0 stall cycles.
//   - Each cycle dmem_ready is low costs 1 cycle.
//  wait_cnt width: $clog2(MEM_TIMEOUT+1). It never wraps; it saturates into ERROR.
//  Reset asserted mid-wait: returns to RUN immediately and clears mem_error.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//   - stall_cycles +1 on every cycle in which StallF=1.
//   - flush_count +1 on every cycle in which FlushE=1.
//   - Both counters wrap modulo 2^PERF_W and are cleared by reset.
//  HAZARD_PERF_EN undefined: the counter ports and their logic are absent.
// STRUCTURE
//  hazard_pkg holds:
//   - typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} hz_state_t;
//   - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
//  Sub-module forward_select (Rs, RdM, RdW, RegWriteM, RegWriteW -> Forward[1:0]), instantiated
//  twice (operands A and B).
// TESTING
//  1. add x5 in M, Rs1E=5, RegWriteM=1 -> ForwardAE=10. Same with RdW=5 only -> 01.
//     RdM=0 -> 00.
//  2. Load with RdE=7 and Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; next cycle
//     ForwardBE=01 when the load reaches W.
//  3. PCSrcE=1 together with lw_stall conditions -> FlushD=FlushE=1, StallF=0.
//  4. dmem_req=1 with dmem_ready low for 3 cycles -> all four stalls high for exactly 3 cycles,
//     state returns to RUN.
//  5. dmem_ready held low 16 cycles -> ERROR after cycle 15, mem_error=1 stays high; reset_n
//     pulse clears it.
//  6. HAZARD_PERF_EN defined: run tests 2 and 4 -> stall_cycles=4, flush_count=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encoding and forwarding select codes for the hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_select.sv
// rtl/forward_select.sv - ALU operand bypass select for one execute-stage source register
// The memory-stage producer is younger than the writeback one, so it wins.
module forward_select
  import hazard_pkg::*;
(
  input  logic [4:0] Rs,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] Forward
);

  always_comb begin
    Forward = FWD_RF;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs)) begin
      Forward = FWD_MEM;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs)) begin
      Forward = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush/forward sequencer for the 5-stage RV32 pipeline
// Optional performance counters (stall_cycles, flush_count, PERF_W) with HAZARD_PERF_EN.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       ResultSrcE0,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       PCSrcE,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       mem_error
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             lw_stall;
  logic             mem_stall;
  logic [1:0]       fwd_a, fwd_b;

  forward_select u_fwd_a (
    .Rs        (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Forward   (fwd_a)
  );

  forward_select u_fwd_b (
    .Rs        (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Forward   (fwd_b)
  );

  assign lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
  assign mem_stall = dmem_req && !dmem_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        // A withdrawn request ends the wait just like a completed one.
        if (!dmem_req || dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = ERROR;
      end
    endcase

    if (!reset_n) begin
      StallF = 1'b0;
    end else if ((state_q == ERROR) || mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign ForwardAE = reset_n ? fwd_a : FWD_RF;
  assign ForwardBE = reset_n ? fwd_b : FWD_RF;
  assign mem_error = (state_q == ERROR);

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cycles_q;
  logic [PERF_W-1:0] flush_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (StallF) stall_cycles_q <= stall_cycles_q + PERF_W'(1);
      if (FlushE) flush_count_q  <= flush_count_q + PERF_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - randomized self-checking bench for hazard_controller (HAZARD_PERF_EN aware)
module tb_hazard_controller;

  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, dmem_req, dmem_ready;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, mem_error;
  logic [1:0] ForwardAE, ForwardBE;
  logic [5:0] ctrl;
  logic [10:0] obs;

  int checks = 0;
  int errors = 0;

  // Reference model: length of the current unbroken memory wait and the sticky error.
  int m_waited = 0;
  bit m_err = 1'b0;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
  logic [31:0] m_stall_cnt = '0;
  logic [31:0] m_flush_cnt = '0;
`endif

  typedef struct packed {
    logic [4:0] rs1e;
    logic [4:0] rs2e;
    logic [4:0] rdm;
    logic [4:0] rdw;
    logic       rwm;
    logic       rww;
    logic [1:0] ea;
    logic [1:0] eb;
  } fwd_vec_t;

  fwd_vec_t fwd_tbl [0:5] = '{
    '{5'd5, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 2'b10, 2'b00},
    '{5'd5, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 2'b01, 2'b00},
    '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 2'b00},
    '{5'd6, 5'd1, 5'd6, 5'd6, 1'b1, 1'b1, 2'b10, 2'b00},
    '{5'd1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b1, 2'b00, 2'b01},
    '{5'd3, 5'd3, 5'd3, 5'd8, 1'b1, 1'b1, 2'b10, 2'b10}
  };

  always #5 clk = ~clk;

  assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE};
  assign obs  = {ctrl, ForwardAE, ForwardBE, mem_error};

  hazard_controller #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .RdM         (RdM),
    .RdW         (RdW),
    .ResultSrcE0 (ResultSrcE0),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .PCSrcE      (PCSrcE),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .mem_error   (mem_error)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [10:0] ref_out();
    logic [3:0] st;
    logic [1:0] fl;
    bit load_use;
    if (!reset_n) return 11'd0;
    st = 4'b0000;
    fl = 2'b00;
    load_use = ResultSrcE0 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    if (m_err || (dmem_req && !dmem_ready)) st = 4'b1111;
    else if (PCSrcE) fl = 2'b11;
    else if (load_use) begin
      st = 4'b1100;
      fl = 2'b01;
    end
    return {st, fl, ref_fwd(Rs1E), ref_fwd(Rs2E), m_err};
  endfunction

  task automatic model_tick();
    logic [10:0] e;
    e = ref_out();
    if (!reset_n) begin
      m_waited = 0;
      m_err = 1'b0;
`ifdef HAZARD_PERF_EN
      m_stall_cnt = '0;
      m_flush_cnt = '0;
`endif
    end else begin
`ifdef HAZARD_PERF_EN
      m_stall_cnt = m_stall_cnt + 32'(e[10]);
      m_flush_cnt = m_flush_cnt + 32'(e[5]);
`endif
      if (!m_err) begin
        if (dmem_req && !dmem_ready) begin
          m_waited++;
          if (m_waited >= MEM_TIMEOUT) m_err = 1'b1;
        end else begin
          m_waited = 0;
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE0 = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcE = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    dmem_req = 1'b1; PCSrcE = 1'b1; RegWriteM = 1'b1; RdM = 5'd3; Rs1E = 5'd3; Rs2E = 5'd3;
    settle();
    checks++;
    if (obs !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 11'd0);
    end
    advance();
    clear_inputs();
    reset_n = 1'b1;
    settle();
    checks++;
    if (obs !== 11'd0) begin
      errors++;
      $display("FAIL after_reset_idle: got %b expected %b", obs, 11'd0);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_count);
    end
`endif
    advance();
  endtask

  task automatic test_forwarding();
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      Rs1E = fwd_tbl[i].rs1e; Rs2E = fwd_tbl[i].rs2e;
      RdM = fwd_tbl[i].rdm; RdW = fwd_tbl[i].rdw;
      RegWriteM = fwd_tbl[i].rwm; RegWriteW = fwd_tbl[i].rww;
      settle();
      checks++;
      if (ForwardAE !== fwd_tbl[i].ea || ForwardBE !== fwd_tbl[i].eb) begin
        errors++;
        $display("FAIL fwd_directed[%0d]: got A=%b B=%b expected A=%b B=%b",
                 i, ForwardAE, ForwardBE, fwd_tbl[i].ea, fwd_tbl[i].eb);
      end
      advance();
    end
    for (int i = 0; i < 60; i++) begin
      clear_inputs();
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      settle();
      checks++;
      if (ForwardAE !== ref_fwd(Rs1E) || ForwardBE !== ref_fwd(Rs2E)) begin
        errors++;
        $display("FAIL fwd_random[%0d]: got A=%b B=%b expected A=%b B=%b",
                 i, ForwardAE, ForwardBE, ref_fwd(Rs1E), ref_fwd(Rs2E));
      end
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd2; Rs2D = 5'd7;
    settle();
    checks++;
    if (ctrl !== 6'b110001) begin
      errors++;
      $display("FAIL load_use_bubble: got %b expected %b", ctrl, 6'b110001);
    end
    advance();
    clear_inputs();
    RdW = 5'd7; RegWriteW = 1'b1; Rs2E = 5'd7; Rs2D = 5'd7;
    settle();
    checks++;
    if (ForwardBE !== 2'b01 || ctrl !== 6'b000000) begin
      errors++;
      $display("FAIL load_use_forward: got fwdB=%b ctrl=%b expected fwdB=01 ctrl=000000", ForwardBE, ctrl);
    end
    advance();
    clear_inputs();
    ResultSrcE0 = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
    settle();
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++;
      $display("FAIL load_x0_no_stall: got %b expected %b", ctrl, 6'b000000);
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_branch_priority();
    clear_inputs();
    PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    settle();
    checks++;
    if (ctrl !== 6'b000011) begin
      errors++;
      $display("FAIL branch_over_load: got %b expected %b", ctrl, 6'b000011);
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    dmem_req = 1'b1; dmem_ready = 1'b0; PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (ctrl !== 6'b111100 || mem_error !== 1'b0) begin
        errors++;
        $display("FAIL mem_wait_cycle[%0d]: got ctrl=%b err=%b expected ctrl=111100 err=0", i, ctrl, mem_error);
      end
      advance();
    end
    dmem_ready = 1'b1;
    settle();
    checks++;
    if (ctrl !== 6'b000011) begin
      errors++;
      $display("FAIL mem_wait_release: got %b expected %b", ctrl, 6'b000011);
    end
    advance();
    clear_inputs();
    dmem_req = 1'b1; dmem_ready = 1'b1;
    settle();
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++;
      $display("FAIL mem_zero_latency: got %b expected %b", ctrl, 6'b000000);
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_withdraw();
    clear_inputs();
    for (int i = 0; i < 25; i++) begin
      dmem_req = (i != 12);
      dmem_ready = 1'b0;
      settle();
      checks++;
      if (obs !== ref_out() || mem_error !== 1'b0) begin
        errors++;
        $display("FAIL withdraw[%0d]: got %b expected %b", i, obs, ref_out());
      end
      advance();
    end
    clear_inputs();
    settle();
    advance();
  endtask

  task automatic test_timeout();
    clear_inputs();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= MEM_TIMEOUT; i++) begin
      settle();
      checks++;
      if (mem_error !== 1'b0 || ctrl !== 6'b111100) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: got err=%b ctrl=%b expected err=0 ctrl=111100", i, mem_error, ctrl);
      end
      advance();
    end
    dmem_req = 1'b0; PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (mem_error !== 1'b1 || ctrl !== 6'b111100) begin
        errors++;
        $display("FAIL timeout_sticky[%0d]: got err=%b ctrl=%b expected err=1 ctrl=111100", i, mem_error, ctrl);
      end
      advance();
    end
    reset_n = 1'b0;
    settle();
    checks++;
    if (obs !== 11'd0) begin
      errors++;
      $display("FAIL timeout_reset_outputs: got %b expected %b", obs, 11'd0);
    end
    advance();
    reset_n = 1'b1;
    clear_inputs();
    settle();
    checks++;
    if (mem_error !== 1'b0 || ctrl !== 6'b000000) begin
      errors++;
      $display("FAIL timeout_cleared: got err=%b ctrl=%b expected err=0 ctrl=000000", mem_error, ctrl);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
      ResultSrcE0 = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      PCSrcE = ($urandom_range(0, 3) == 0);
      dmem_req = ($urandom_range(0, 2) == 0);
      dmem_ready = 1'($urandom);
      if (i >= 200 && i < 230) begin
        dmem_req = 1'b1;
        dmem_ready = 1'b0;
      end
      reset_n = !((i == 260) || ($urandom_range(0, 149) == 0));
      settle();
      checks++;
      if (obs !== ref_out()) begin
        errors++;
        $display("FAIL random[%0d]: got %b expected %b", i, obs, ref_out());
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (stall_cycles !== (reset_n ? m_stall_cnt : 32'd0) ||
          flush_count !== (reset_n ? m_flush_cnt : 32'd0)) begin
        errors++;
        $display("FAIL random_perf[%0d]: got %0d/%0d expected %0d/%0d", i, stall_cycles, flush_count,
                 reset_n ? m_stall_cnt : 32'd0, reset_n ? m_flush_cnt : 32'd0);
      end
`endif
      advance();
    end
    reset_n = 1'b1;
    clear_inputs();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    reset_n = 1'b0;
    clear_inputs();
    settle();
    advance();
    reset_n = 1'b1;
    settle();
    advance();
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    settle();
    advance();
    clear_inputs();
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      advance();
    end
    dmem_ready = 1'b1;
    settle();
    advance();
    clear_inputs();
    settle();
    checks++;
    if (stall_cycles !== 32'd4 || flush_count !== 32'd1) begin
      errors++;
      $display("FAIL perf_counters: got %0d/%0d expected 4/1", stall_cycles, flush_count);
    end
    advance();
  endtask
`endif

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_withdraw();
    test_timeout();
    test_random();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
